// File: rtl/sprite_blitter_if.sv
// Signal bundle for sprite_blitter: blit command/status, sprite ROM read port
// and framebuffer write port. The blitter takes the master side.
interface sprite_blitter_if #(
    parameter int ADDR_W = 12,
    parameter int PIX_W  = 12
);
    logic              start;
    logic [10:0]       pos_x;
    logic [9:0]        pos_y;
    logic [1:0]        rotation;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rom_addr;
    logic [PIX_W-1:0]  rom_data;
    logic              fb_we;
    logic [10:0]       fb_x;
    logic [9:0]        fb_y;
    logic [PIX_W-1:0]  fb_data;
    logic              fb_ready;

    // Framebuffer write: fb_we is the valid; a write transfers on each cycle with
    // fb_we && fb_ready, and fb_x/fb_y/fb_data hold while fb_we is high and fb_ready low.
    modport master (
        input  start, pos_x, pos_y, rotation, rom_data, fb_ready,
        output busy, done, rom_addr, fb_we, fb_x, fb_y, fb_data
    );

    modport slave (
        output start, pos_x, pos_y, rotation, rom_data, fb_ready,
        input  busy, done, rom_addr, fb_we, fb_x, fb_y, fb_data
    );
endinterface

// File: rtl/sprite_blitter.sv
// Walks the sprite ROM in source order and writes each pixel to its rotated, clipped
// screen position. Optional colour keying is enabled by SPRITE_BLIT_TRANSPARENCY_EN.
module sprite_blitter #(
    parameter int               SPR_WIDTH    = 64,
    parameter int               SPR_HEIGHT   = 64,
    parameter int               SCREEN_W     = 640,
    parameter int               SCREEN_H     = 480,
    parameter int               PIX_W        = 12,
    parameter logic [PIX_W-1:0] TRANSP_COLOR = '0
) (
    input  logic             clk,
    input  logic             rst,
    sprite_blitter_if.master bus,
    output logic [2:0]       o_dbg_state
);
    localparam int ADDR_W = $clog2(SPR_WIDTH * SPR_HEIGHT);
    localparam int CW     = (SPR_WIDTH > 1) ? $clog2(SPR_WIDTH) : 1;
    localparam logic [CW-1:0] MAXC = CW'(SPR_WIDTH - 1);
    localparam logic [CW-1:0] MAXR = CW'(SPR_HEIGHT - 1);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_PIX, S_WRITE, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_sx, r_sy, w_rx, w_ry;
    logic [10:0]      r_pos_x;
    logic [9:0]       r_pos_y;
    logic [1:0]       r_rot;
    logic             r_fb_we;
    logic [10:0]      r_fb_x;
    logic [9:0]       r_fb_y;
    logic [PIX_W-1:0] r_fb_data;
    logic [11:0]      w_scr_x;
    logic [10:0]      w_scr_y;
    logic             w_clip, w_transp, w_skip, w_last, w_step;

    always_comb begin
        w_rx = r_sx;
        w_ry = r_sy;
        case (r_rot)
            2'd1:    begin w_rx = MAXR - r_sy; w_ry = r_sx;        end
            2'd2:    begin w_rx = MAXC - r_sx; w_ry = MAXR - r_sy; end
            2'd3:    begin w_rx = r_sy;        w_ry = MAXC - r_sx; end
            default: ;
        endcase
    end

    // One extra bit so a sprite hanging off the far edge clips instead of wrapping.
    assign w_scr_x = {1'b0, r_pos_x} + 12'(w_rx);
    assign w_scr_y = {1'b0, r_pos_y} + 11'(w_ry);
    assign w_clip  = (w_scr_x >= 12'(SCREEN_W)) || (w_scr_y >= 11'(SCREEN_H));

`ifdef SPRITE_BLIT_TRANSPARENCY_EN
    assign w_transp = (bus.rom_data == TRANSP_COLOR);
`else
    localparam bit TRANSP_EN = 1'b0;
    assign w_transp = TRANSP_EN && (bus.rom_data == TRANSP_COLOR);
`endif

    assign w_skip = w_clip || w_transp;
    assign w_last = (r_sx == MAXC) && (r_sy == MAXR);
    assign w_step = ((r_state == S_PIX) && w_skip) || ((r_state == S_WRITE) && bus.fb_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_READ;
            S_READ:  w_next = S_PIX;
            S_PIX:   w_next = w_skip ? (w_last ? S_DONE : S_READ) : S_WRITE;
            S_WRITE: if (bus.fb_ready) w_next = w_last ? S_DONE : S_READ;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (r_state == S_READ) || (r_state == S_PIX) || (r_state == S_WRITE);
        bus.done = (r_state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sx      <= '0;
            r_sy      <= '0;
            r_pos_x   <= '0;
            r_pos_y   <= '0;
            r_rot     <= '0;
            r_fb_we   <= 1'b0;
            r_fb_x    <= '0;
            r_fb_y    <= '0;
            r_fb_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_pos_x <= bus.pos_x;
                    r_pos_y <= bus.pos_y;
                    r_rot   <= bus.rotation;
                    r_sx    <= '0;
                    r_sy    <= '0;
                end
                S_PIX: if (!w_skip) begin
                    r_fb_we   <= 1'b1;
                    r_fb_x    <= w_scr_x[10:0];
                    r_fb_y    <= w_scr_y[9:0];
                    r_fb_data <= bus.rom_data;
                end
                S_WRITE: if (bus.fb_ready) r_fb_we <= 1'b0;
                default: ;
            endcase
            if (w_step) begin
                if (r_sx == MAXC) begin
                    r_sx <= '0;
                    r_sy <= (r_sy == MAXR) ? '0 : r_sy + 1'b1;
                end else begin
                    r_sx <= r_sx + 1'b1;
                end
            end
        end
    end

    assign bus.rom_addr = ADDR_W'(r_sy) * ADDR_W'(SPR_WIDTH) + ADDR_W'(r_sx);
    assign bus.fb_we    = r_fb_we;
    assign bus.fb_x     = r_fb_x;
    assign bus.fb_y     = r_fb_y;
    assign bus.fb_data  = r_fb_data;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_sprite_blitter.sv
// Directed and randomized bench for sprite_blitter on a 4x4 sprite with a reference
// model that places pixels by repeated quarter turns, then offsets and clips.
module tb_sprite_blitter;
    localparam int W      = 4;
    localparam int H      = 4;
    localparam int SCR_W  = 640;
    localparam int SCR_H  = 480;
    localparam int BUDGET = 2000;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dbg_state;
    logic [2:0] idle_code;

    sprite_blitter_if #(.ADDR_W(4), .PIX_W(12)) bus ();

    sprite_blitter #(
        .SPR_WIDTH(W), .SPR_HEIGHT(H), .SCREEN_W(SCR_W), .SCREEN_H(SCR_H),
        .PIX_W(12), .TRANSP_COLOR(12'h000)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    logic [11:0] rom [W*H];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (bus.fb_we && bus.fb_ready) obs_q.push_back({bus.fb_x, bus.fb_y, bus.fb_data});
        if (bus.done) done_cnt++;
    end

    int n_vec = 0;
    int n_err = 0;
    int exp_lat, lat, obs_base, done_base;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] obs_at(input int i);
        if (i < obs_q.size()) return obs_q[i];
        return 'x;
    endfunction

    task automatic rom_default();
        for (int i = 0; i < W*H; i++) rom[i] = 12'h100 + 12'(i);
    endtask

    // Reference: expected writes in source order and the stall-free cycle count.
    task automatic build_exp(input int px, input int py, input int rot);
        int x, y, t;
        logic [11:0] pix;
        bit skip;
        exp_q.delete();
        exp_lat = 1;
        for (int sy = 0; sy < H; sy++) begin
            for (int sx = 0; sx < W; sx++) begin
                x = sx;
                y = sy;
                for (int r = 0; r < rot; r++) begin
                    t = x;
                    x = W - 1 - y;
                    y = t;
                end
                x += px;
                y += py;
                pix  = rom[sy*W + sx];
                skip = (x >= SCR_W) || (y >= SCR_H);
`ifdef SPRITE_BLIT_TRANSPARENCY_EN
                if (pix == 12'h000) skip = 1'b1;
`endif
                if (skip) exp_lat += 2;
                else begin
                    exp_q.push_back({11'(x), 10'(y), pix});
                    exp_lat += 3;
                end
            end
        end
    endtask

    task automatic launch(input int px, input int py, input int rot);
        build_exp(px, py, rot);
        obs_base     = obs_q.size();
        done_base    = done_cnt;
        bus.fb_ready = 1'b1;
        bus.pos_x    = 11'(px);
        bus.pos_y    = 10'(py);
        bus.rotation = 2'(rot);
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
    endtask

    task automatic finish(input string tag, input bit rnd_ready, input int extra);
        while (bus.done !== 1'b1 && lat < BUDGET) begin
            if (rnd_ready) bus.fb_ready = 1'($urandom_range(0, 1));
            bus.pos_x    = 11'($urandom);
            bus.pos_y    = 10'($urandom);
            bus.rotation = 2'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_done_seen"}, 64'(lat < BUDGET), 1);
        if (!rnd_ready) chk({tag, "_latency"}, lat, exp_lat + extra);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, "_idle_after"}, {bus.busy, bus.done, dbg_state}, {2'b00, idle_code});
        chk({tag, "_done_count"}, done_cnt - done_base, 1);
        chk({tag, "_writes"}, obs_q.size() - obs_base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), obs_at(obs_base + i), exp_q[i]);
    endtask

    task automatic run_blit(input string tag, input int px, input int py, input int rot,
                            input bit rnd_ready);
        launch(px, py, rot);
        finish(tag, rnd_ready, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] snap;
        logic [2:0]  st;
        bit          hit;

        rom_default();
        rst = 1'b1;
        bus.start = 1'b0; bus.fb_ready = 1'b1;
        bus.pos_x = '0; bus.pos_y = '0; bus.rotation = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {bus.busy, bus.done, bus.fb_we, bus.fb_x, bus.fb_y, bus.fb_data,
                           bus.rom_addr}, 0);
        idle_code = dbg_state;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_hold", {bus.busy, dbg_state}, {1'b0, idle_code});

        run_blit("rot0", 100, 50, 0, 0);
        chk("rot0_first", obs_at(obs_base), {11'd100, 10'd50, 12'h100});
        chk("rot0_last", obs_at(obs_base + 15), {11'd103, 10'd53, 12'h10F});
        chk("rot0_lat49", lat, 49);

        run_blit("rot1", 100, 50, 1, 0);
        chk("rot1_src10", obs_at(obs_base + 1), {11'd103, 10'd51, 12'h101});
        run_blit("rot3", 100, 50, 3, 0);
        chk("rot3_src10", obs_at(obs_base + 1), {11'd100, 10'd52, 12'h101});
        run_blit("rot2", 100, 50, 2, 0);
        chk("rot2_src10", obs_at(obs_base + 1), {11'd102, 10'd53, 12'h101});

        run_blit("clip_corner", 638, 478, 0, 0);
        chk("clip_corner_n4", obs_q.size() - obs_base, 4);
        run_blit("clip_nowrap", 2046, 1022, 1, 0);
        chk("clip_nowrap_n0", obs_q.size() - obs_base, 0);

        // Stall the first write for five cycles and fire a stray start meanwhile.
        launch(100, 50, 0);
        bus.fb_ready = 1'b0;
        while (bus.fb_we !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("stall_we_seen", bus.fb_we, 1);
        snap = {bus.fb_x, bus.fb_y, bus.fb_data};
        st   = dbg_state;
        chk("stall_first", snap, {11'd100, 10'd50, 12'h100});
        for (int k = 1; k <= 5; k++) begin
            if (k == 2) begin
                bus.start = 1'b1; bus.pos_x = '0; bus.pos_y = '0; bus.rotation = 2'd3;
            end
            @(posedge clk); #1;
            lat++;
            bus.start = 1'b0;
            chk($sformatf("stall_hold%0d", k), {bus.fb_we, bus.fb_x, bus.fb_y, bus.fb_data,
                                                 dbg_state}, {1'b1, snap, st});
        end
        bus.fb_ready = 1'b1;
        finish("stall", 0, 5);

        rom[5] = 12'h000;
        run_blit("transp", 100, 50, 0, 0);
        hit = 1'b0;
        for (int i = obs_base; i < obs_q.size(); i++)
            if (obs_q[i][32:12] == {11'd101, 10'd51}) hit = 1'b1;
`ifdef SPRITE_BLIT_TRANSPARENCY_EN
        chk("transp_n", obs_q.size() - obs_base, 15);
        chk("transp_skip_101_51", hit, 0);
`else
        chk("transp_n", obs_q.size() - obs_base, 16);
        chk("transp_kept_101_51", hit, 1);
`endif
        rom_default();

        // Reset while a write is pending.
        launch(100, 50, 0);
        bus.fb_ready = 1'b0;
        while (bus.fb_we !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("rstw_we_seen", bus.fb_we, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rstw_outs", {bus.fb_we, bus.busy, bus.done, bus.fb_x, bus.fb_y, bus.fb_data,
                          bus.rom_addr}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.fb_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rstw_no_done", done_cnt - done_base, 0);
        chk("rstw_no_write", obs_q.size() - obs_base, 0);
        chk("rstw_idle", {bus.busy, dbg_state}, {1'b0, idle_code});
        run_blit("restart", 100, 50, 0, 0);

        for (int n = 0; n < 8; n++) begin
            int px, py, rot;
            for (int i = 0; i < W*H; i++)
                rom[i] = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
            px  = ($urandom_range(0, 1) == 1) ? $urandom_range(630, 645) : $urandom_range(0, 2047);
            py  = ($urandom_range(0, 1) == 1) ? $urandom_range(470, 485) : $urandom_range(0, 1023);
            rot = $urandom_range(0, 3);
            run_blit($sformatf("rnd%0d", n), px, py, rot, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
